// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell (two half adders + OR)
// walks a WIDTH-bit operand pair LSB first, one bit per clock, behind a start/done handshake.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       dbg_state
);

   // Handshake: start is a request sampled on a rising edge and accepted only in
   // IDLE or DONE (operands and cin captured on that edge); done is a one-cycle
   // result-valid pulse and sum/cout stay stable until the next completion.

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, s_sh;
   logic             carry_q;
   logic [CW-1:0]    cnt;

   logic ha1_s, ha1_c, ha2_c, bit_s, bit_c;
   logic last_bit, accept;

   // Full-adder cell built from two half adders and an OR.
   assign ha1_s = a_sh[0] ^ b_sh[0];
   assign ha1_c = a_sh[0] & b_sh[0];
   assign bit_s = ha1_s ^ carry_q;
   assign ha2_c = ha1_s & carry_q;
   assign bit_c = ha1_c | ha2_c;

   assign last_bit = (cnt == LAST);
   assign accept   = start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == RUN);
      done      = (state == DONE);
      dbg_state = state;
   end

   // The counter is not advanced on the last bit so it only restarts via reload on start.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         s_sh    <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else if (accept) begin
         a_sh    <= op_a;
         b_sh    <= op_b;
         carry_q <= cin;
         cnt     <= '0;
      end else if (state == RUN) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         s_sh    <= {bit_s, s_sh[WIDTH-1:1]};
         carry_q <= bit_c;
         if (last_bit) begin
            sum  <= {bit_s, s_sh[WIDTH-1:1]};
            cout <= bit_c;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule
